wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, is the number of granted cycles without s_ack_i before a bus-timeout abort; legal range is 2..65535.
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 m0_stb_i / m1_stb_i  input  1 each  master strobe, held high until ack.
REQ-005 m0_we_i / m1_we_i  input  1 each  master write enable.
REQ-006 m0_adr_i / m1_adr_i  input  32 each  master address.
REQ-007 m0_dat_i / m1_dat_i  input  32 each  master write data.
REQ-008 m0_dat_o / m1_dat_o  output  32 each  read data returned to master.
REQ-009 m0_ack_o / m1_ack_o  output  1 each  transfer acknowledge to master.
REQ-010 m0_err_o / m1_err_o  output  1 each  bus-timeout error pulse.
REQ-011 s_stb_o, s_we_o  output  1 each  strobe and write enable toward the bus.
REQ-012 s_adr_o, s_dat_o  output  32 each  address and write data toward the bus.
REQ-013 s_dat_i, s_ack_i  input  32 / 1  read data and acknowledge from the bus.
REQ-014 gnt_o  output  2  one-hot grant: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-015 The FSM SHALL have the states IDLE, GNT0, GNT1 and DRAIN, with a registered state and a registered last-served flag (last).
REQ-016 IDLE: with m0_stb_i alone -> GNT0; with m1_stb_i alone -> GNT1; with both -> grant the master other than last; with neither -> stay in IDLE.
REQ-017 Grant SHALL take effect one cycle after the request is sampled in IDLE; gnt_o SHALL be 01 in GNT0, 10 in GNT1, and 00 in IDLE and DRAIN.
REQ-018 Entering GNTx SHALL set last to x.
REQ-019 In GNTx: s_stb_o = mx_stb_i, s_we_o = mx_we_i, s_adr_o = mx_adr_i, s_dat_o = mx_dat_i; outside GNT states s_stb_o = 0, s_we_o = 0, and addr/data are 0.
REQ-020 mx_ack_o SHALL equal s_ack_i combinationally only while in GNTx; the non-granted master's ack SHALL be 0.
REQ-021 m0_dat_o and m1_dat_o SHALL equal s_dat_i at all times except during a timeout abort cycle (REQ-026).
REQ-022 GNTx -> IDLE on the cycle mx_stb_i is sampled low; at least one IDLE cycle SHALL separate consecutive grants.
REQ-023 A master dropping its strobe before ack SHALL end the grant per REQ-022; no ack is owed to it.
REQ-024 s_ack_i asserted while in IDLE or DRAIN SHALL be ignored.

Reset
REQ-025 While rst_i is high: state = IDLE, last = 1 (m0 wins first tie), timeout counter = 0, gnt_o = 00, all ack/err/stb outputs = 0; reset mid-transfer SHALL abort it immediately with no ack issued.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on grant entry and on each s_ack_i, and increment each GNTx cycle otherwise; when it reaches TIMEOUT_CYC-1 without ack, the arbiter SHALL pulse mx_ack_o and mx_err_o high for one cycle with mx_dat_o = 32'h0, deassert s_stb_o from the next cycle, and enter DRAIN.
REQ-027 DRAIN -> IDLE once the aborted master's strobe is sampled low.
REQ-028 Without ARB_TIMEOUT_EN, no counter SHALL exist, DRAIN SHALL be unreachable, and m0_err_o/m1_err_o SHALL be tied to 0.

Verification
REQ-029 m0_stb_i high alone, s_ack_i at 3rd grant cycle with s_dat_i = 32'h1234_5678 -> gnt_o = 01 one cycle after request; m0_ack_o = 1 with m0_dat_o = 32'h1234_5678; m1_ack_o = 0.
REQ-030 Both strobes rise together after reset -> m0 granted first; after m0 drops its strobe, one IDLE cycle, then gnt_o = 10; a repeated simultaneous request then goes to m0 (alternation).
REQ-031 m1 requests while m0 is mid-transfer -> s_adr_o stays m0_adr_i until m0_stb_i drops; m1 is granted 2 cycles later.
REQ-032 ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 8, no s_ack_i -> after 8 granted cycles m0_ack_o = m0_err_o = 1 for one cycle with m0_dat_o = 0, gnt_o = 00 (DRAIN) until the strobe drops; macro undefined -> grant held indefinitely and err outputs stay 0.
REQ-033 rst_i pulsed high mid-grant -> gnt_o = 00 and s_stb_o = 0 immediately (asynchronous); after release, the m0/m1 tie goes to m0.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
//
// Two-master to one-slave Wishbone-style arbiter. One master at a time owns
// the bus. When both masters request in the same IDLE cycle, the master that
// was not served last wins. A grant lasts while the owning master holds its
// strobe. At least one IDLE cycle always separates consecutive grants.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   A 16-bit watchdog counts granted cycles that pass without s_ack_i. If
//   TIMEOUT_CYC cycles elapse without an ack, the owner receives a
//   one-cycle ack+err pulse with zeroed read data. The arbiter then stops
//   strobing the bus and waits in DRAIN until that master drops its strobe.
//   When ARB_TIMEOUT_EN is undefined there is no counter, DRAIN cannot be
//   reached and both err outputs are tied low.
//
// Parameters
//   TIMEOUT_CYC  granted cycles without ack before abort (2..65535)
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   m0_* / m1_*               master-side stb/we/adr/dat in, dat/ack/err out
//   s_stb_o, s_we_o           strobe / write enable toward the bus
//   s_adr_o, s_dat_o          address / write data toward the bus
//   s_dat_i, s_ack_i          read data / acknowledge from the bus
//   gnt_o                     one-hot grant (bit0 = m0, bit1 = m1, 00 idle)
// ---------------------------------------------------------------------------
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GNT0  = 2'b01;
  localparam logic [1:0] ST_GNT1  = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  // Master served most recently (0 = m0, 1 = m1); loses the next tie.
  logic       r_last;
  logic       w_last_nxt;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_abort;
  logic       w_drain_stb;

  assign w_gnt0 = (r_state == ST_GNT0);
  assign w_gnt1 = (r_state == ST_GNT1);

  // In DRAIN the aborted master is always the last one granted.
  assign w_drain_stb = r_last ? m1_stb_i : m0_stb_i;

  // -------------------------------------------------------------------------
  // Bus-timeout watchdog
  // -------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;
  logic        w_cur_stb;

  assign w_cur_stb = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);

  // The abort fires in the cycle the counter reaches its last value, but
  // only when no ack arrives in that cycle and the owner is still strobing.
  assign w_abort = w_cur_stb & ~s_ack_i & (r_cnt == LP_CNT_LAST);

  // The counter is zero in IDLE, so it is already clear on grant entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if ((w_gnt0 | w_gnt1) && !s_ack_i) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign m0_err_o = w_gnt0 & w_abort;
  assign m1_err_o = w_gnt1 & w_abort;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 32'd1);
  assign w_abort  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Arbitration FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          if (r_last) begin
            w_state_nxt = ST_GNT0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_GNT1;
            w_last_nxt  = 1'b1;
          end
        end else if (m0_stb_i) begin
          w_state_nxt = ST_GNT0;
          w_last_nxt  = 1'b0;
        end else if (m1_stb_i) begin
          w_state_nxt = ST_GNT1;
          w_last_nxt  = 1'b1;
        end
      end
      ST_GNT0: begin
        if (!m0_stb_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_abort) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_GNT1: begin
        if (!m1_stb_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_abort) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!w_drain_stb) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Bus-side multiplexer
  // -------------------------------------------------------------------------
  always_comb begin
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (w_gnt0) begin
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (w_gnt1) begin
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign gnt_o = {w_gnt1, w_gnt0};

  // -------------------------------------------------------------------------
  // Master-side return path
  // -------------------------------------------------------------------------
  // Ack passes straight through to the owner. Read data is broadcast to
  // both masters, except that the owner sees zero during an abort pulse.
  assign m0_ack_o = w_gnt0 & (s_ack_i | w_abort);
  assign m1_ack_o = w_gnt1 & (s_ack_i | w_abort);
  assign m0_dat_o = (w_gnt0 & w_abort) ? '0 : s_dat_i;
  assign m1_dat_o = (w_gnt1 & w_abort) ? '0 : s_dat_i;

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int unsigned TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic        m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_stb_o, s_we_o;
  logic [1:0]  gnt_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  wb_master_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  // Reference model: who owns the bus (-1 none), whether an aborted master
  // is being drained, who was served last, and ack-less granted cycles.
  int          mo_owner;
  bit          mo_drain;
  int          mo_dw;
  int          mo_last;
  int unsigned mo_wait;

  function automatic bit stb_of(int w);
    return (w == 0) ? m0_stb_i : m1_stb_i;
  endfunction

  function automatic bit mo_abort();
    return TO_EN && (mo_owner >= 0) && stb_of(mo_owner) && !s_ack_i && (mo_wait == TO - 1);
  endfunction

  task automatic model_reset();
    mo_owner = -1;
    mo_drain = 1'b0;
    mo_dw    = 0;
    mo_last  = 1;
    mo_wait  = 0;
  endtask

  task automatic model_step();
    int who;
    if (rst_i) begin
      model_reset();
    end else if (mo_drain) begin
      if (!stb_of(mo_dw)) mo_drain = 1'b0;
    end else if (mo_owner < 0) begin
      who = -1;
      if (m0_stb_i && m1_stb_i) who = 1 - mo_last;
      else if (m0_stb_i)        who = 0;
      else if (m1_stb_i)        who = 1;
      if (who >= 0) begin
        mo_owner = who;
        mo_last  = who;
        mo_wait  = 0;
      end
    end else begin
      if (!stb_of(mo_owner)) begin
        mo_owner = -1;
      end else if (mo_abort()) begin
        mo_drain = 1'b1;
        mo_dw    = mo_owner;
        mo_owner = -1;
      end else if (s_ack_i) begin
        mo_wait = 0;
      end else begin
        mo_wait = mo_wait + 1;
      end
    end
  endtask

  function automatic logic [135:0] exp_vec();
    logic [1:0]  g;
    logic        st, we, a0, a1, e0, e1;
    logic [31:0] ad, dt, d0, d1;
    bit          ab;
    ab = mo_abort();
    g  = (mo_owner == 0) ? 2'b01 : (mo_owner == 1) ? 2'b10 : 2'b00;
    st = 1'b0; we = 1'b0; ad = '0; dt = '0;
    if (mo_owner == 0) begin st = m0_stb_i; we = m0_we_i; ad = m0_adr_i; dt = m0_dat_i; end
    if (mo_owner == 1) begin st = m1_stb_i; we = m1_we_i; ad = m1_adr_i; dt = m1_dat_i; end
    a0 = (mo_owner == 0) && (s_ack_i || ab);
    a1 = (mo_owner == 1) && (s_ack_i || ab);
    e0 = (mo_owner == 0) && ab;
    e1 = (mo_owner == 1) && ab;
    d0 = ((mo_owner == 0) && ab) ? 32'h0 : s_dat_i;
    d1 = ((mo_owner == 1) && ab) ? 32'h0 : s_dat_i;
    return {g, st, we, ad, dt, a0, a1, e0, e1, d0, d1};
  endfunction

  function automatic logic [135:0] act_vec();
    return {gnt_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o,
            m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
  endfunction

  task automatic advance();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    m0_we_i = 1'b0; m1_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; model_reset();
    m0_stb_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1; s_dat_i = $urandom;
    @(negedge clk_i);
    n_vec++;
    if ({gnt_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=%b", {gnt_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 7'b0);
    end
    n_vec++;
    if (m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) begin
      n_bad++;
      $display("FAIL reset_dat_passthru got=%h/%h exp=%h", m0_dat_o, m1_dat_o, s_dat_i);
    end
    advance();
    rst_i = 1'b0; clear_inputs();
    advance();
  endtask

  task automatic test_single_m0();
    m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'hA000_0010; s_dat_i = 32'hDEAD_0001;
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL single_req_cycle gnt got=%b exp=00", gnt_o); end
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b01 || s_adr_o !== 32'hA000_0010 || s_stb_o !== 1'b1) begin
      n_bad++; $display("FAIL single_grant gnt=%b adr=%h stb=%b exp 01/a0000010/1", gnt_o, s_adr_o, s_stb_o);
    end
    advance();
    @(negedge clk_i);
    n_vec++;
    if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL single_noack got=%b exp=0", m0_ack_o); end
    advance();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    @(negedge clk_i);
    n_vec++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1234_5678 || m1_ack_o !== 1'b0) begin
      n_bad++; $display("FAIL single_ack ack0=%b dat0=%h ack1=%b exp 1/12345678/0", m0_ack_o, m0_dat_o, m1_ack_o);
    end
    n_vec++;
    if (m1_dat_o !== 32'h1234_5678) begin n_bad++; $display("FAIL single_dat1 got=%h exp=12345678", m1_dat_o); end
    advance();
    s_ack_i = 1'b0; m0_stb_i = 1'b0;
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL single_release gnt got=%b exp=00", gnt_o); end
  endtask

  task automatic test_alternation();
    rst_i = 1'b1; model_reset();
    advance();
    rst_i = 1'b0;
    m0_stb_i = 1'b1; m1_stb_i = 1'b1; m0_adr_i = 32'h0000_1000; m1_adr_i = 32'h0000_2000;
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b01 || s_adr_o !== 32'h0000_1000) begin
      n_bad++; $display("FAIL alt_first gnt=%b adr=%h exp 01/00001000", gnt_o, s_adr_o);
    end
    advance();
    m0_stb_i = 1'b0;
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL alt_gap gnt got=%b exp=00", gnt_o); end
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b10 || s_adr_o !== 32'h0000_2000) begin
      n_bad++; $display("FAIL alt_second gnt=%b adr=%h exp 10/00002000", gnt_o, s_adr_o);
    end
    advance();
    m1_stb_i = 1'b0;
    advance();
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL alt_third gnt got=%b exp=01", gnt_o); end
    clear_inputs();
    advance();
    advance();
  endtask

  task automatic test_back_to_back();
    m0_stb_i = 1'b1; m0_adr_i = 32'h0BAD_0000;
    advance();
    m1_stb_i = 1'b1; m1_adr_i = 32'h0C0D_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (gnt_o !== 2'b01 || s_adr_o !== 32'h0BAD_0000) begin
        n_bad++; $display("FAIL b2b_hold k=%0d gnt=%b adr=%h exp 01/0bad0000", k, gnt_o, s_adr_o);
      end
      advance();
    end
    m0_stb_i = 1'b0;
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL b2b_gap gnt got=%b exp=00", gnt_o); end
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b10 || s_adr_o !== 32'h0C0D_0000) begin
      n_bad++; $display("FAIL b2b_m1 gnt=%b adr=%h exp 10/0c0d0000", gnt_o, s_adr_o);
    end
    clear_inputs();
    advance();
    advance();
  endtask

  task automatic test_timeout();
    m0_stb_i = 1'b1; m0_adr_i = 32'h7000_0000; s_ack_i = 1'b0;
    advance();
`ifdef ARB_TIMEOUT_EN
    for (int unsigned k = 1; k < TO; k++) begin
      s_dat_i = $urandom | 32'h1;
      @(negedge clk_i);
      n_vec++;
      if (gnt_o !== 2'b01 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
        n_bad++; $display("FAIL to_wait k=%0d gnt=%b ack=%b err=%b exp 01/0/0", k, gnt_o, m0_ack_o, m0_err_o);
      end
      advance();
    end
    s_dat_i = 32'h5555_AAAA;
    @(negedge clk_i);
    n_vec++;
    if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b1 || m0_dat_o !== 32'h0 || m1_dat_o !== 32'h5555_AAAA) begin
      n_bad++; $display("FAIL to_abort ack=%b err=%b dat0=%h dat1=%h exp 1/1/0/5555aaaa", m0_ack_o, m0_err_o, m0_dat_o, m1_dat_o);
    end
    advance();
    m1_stb_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (gnt_o !== 2'b00 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
        n_bad++; $display("FAIL to_drain k=%0d gnt=%b stb=%b ack=%b err=%b exp 00/0/0/0", k, gnt_o, s_stb_o, m0_ack_o, m0_err_o);
      end
      advance();
    end
    m0_stb_i = 1'b0;
    advance();
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL to_after_drain gnt got=%b exp=10", gnt_o); end
`else
    for (int k = 0; k < 3 * TO; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (gnt_o !== 2'b01 || m0_err_o !== 1'b0 || m1_err_o !== 1'b0 || m0_ack_o !== 1'b0) begin
        n_bad++; $display("FAIL noto_hold k=%0d gnt=%b err=%b%b ack=%b exp 01/00/0", k, gnt_o, m0_err_o, m1_err_o, m0_ack_o);
      end
      advance();
    end
`endif
    clear_inputs();
    advance();
    advance();
  endtask

  task automatic test_async_reset();
    m0_stb_i = 1'b1;
    advance();
    m1_stb_i = 1'b1;
    #2;
    s_ack_i = 1'b1;
    rst_i = 1'b1; model_reset();
    #1;
    n_vec++;
    if (gnt_o !== 2'b00 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      n_bad++; $display("FAIL areset_immediate gnt=%b stb=%b ack=%b%b exp 00/0/00", gnt_o, s_stb_o, m0_ack_o, m1_ack_o);
    end
    advance();
    rst_i = 1'b0; s_ack_i = 1'b0;
    advance();
    @(negedge clk_i);
    n_vec++;
    if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL areset_tie gnt got=%b exp=01", gnt_o); end
    clear_inputs();
    advance();
    advance();
  endtask

  task automatic test_random();
    bit ack_seen [2];
    bit rst_prev;
    bit s;
    ack_seen[0] = 1'b0; ack_seen[1] = 1'b0; rst_prev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        s = (m == 0) ? m0_stb_i : m1_stb_i;
        if (s && ack_seen[m])       s = $urandom_range(1, 0) == 0;
        else if (s)                 s = $urandom_range(15, 0) != 0;
        else                        s = $urandom_range(2, 0) == 0;
        if (s && (ack_seen[m] || !((m == 0) ? m0_stb_i : m1_stb_i))) begin
          if (m == 0) begin m0_adr_i = $urandom; m0_dat_i = $urandom; m0_we_i = $urandom_range(1, 0) == 1; end
          else        begin m1_adr_i = $urandom; m1_dat_i = $urandom; m1_we_i = $urandom_range(1, 0) == 1; end
        end
        if (m == 0) m0_stb_i = s; else m1_stb_i = s;
      end
      s_ack_i = $urandom_range(3, 0) == 0;
      s_dat_i = $urandom;
      if (rst_prev) rst_i = 1'b0;
      else if ($urandom_range(299, 0) == 0) begin rst_i = 1'b1; model_reset(); end
      rst_prev = rst_i;
      @(negedge clk_i);
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      ack_seen[0] = m0_ack_o;
      ack_seen[1] = m1_ack_o;
      advance();
    end
    rst_i = 1'b0;
    clear_inputs();
    advance();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_m0();
    test_alternation();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
